// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: control steps, opcodes,
// bus-select codes and flag bit positions.
package proc_pkg;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVT = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_CMP = 3'b110,
    OP_RSV = 3'b111
  } op_t;

  typedef enum logic [1:0] {SEL_B, SEL_MVT, SEL_RX, SEL_G} bus_sel_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add/sub/and/or/cmp with {Z,N,C} flags.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            carry;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      // C means "no borrow", i.e. a >= b unsigned
      OP_SUB, OP_CMP: begin
        result = diff[DATA_W-1:0];
        carry  = ~diff[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[DATA_W-1];
    flags[FLAG_C] = carry;
  end

endmodule

// File: rtl/proc_multicycle_gen.sv
// Multicycle processor core: T0..T3 control FSM, IR, register file, A/G
// registers, shared bus mux and a non-intrusive debug read port.
module proc_multicycle_gen
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       din,
  input  logic              run,
  output logic              done,
  output logic              busy,
  output logic [2:0]        flags,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state, state_next;
  bus_sel_t          bus_sel;
  logic [15:0]       ir;
  logic [DATA_W-1:0] a_reg, g_reg, bus;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rx_val, ry_val, b_val, mvt_val, alu_result;
  logic [2:0]        alu_flags;
  logic              ir_ld, a_ld, g_ld, rf_we;
  op_t               op;
  logic [2:0]        rx, ry;

  assign op      = op_t'(ir[15:13]);
  assign rx      = ir[11:9];
  assign ry      = ir[2:0];
  assign mvt_val = {ir[7:0], {(DATA_W-8){1'b0}}};
  assign b_val   = ir[12] ? {{(DATA_W-9){ir[8]}}, ir[8:0]} : ry_val;
  assign busy    = (state != T0);

  // Register reads beyond NREG return zero rather than indexing out of range.
  always_comb begin
    rx_val   = '0;
    ry_val   = '0;
    dbg_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rx == i[2:0])       rx_val   = regs[i];
      if (ry == i[2:0])       ry_val   = regs[i];
      if (dbg_addr == i[2:0]) dbg_data = regs[i];
    end
  end

  always_comb begin
    case (bus_sel)
      SEL_MVT: bus = mvt_val;
      SEL_RX:  bus = rx_val;
      SEL_G:   bus = g_reg;
      default: bus = b_val;
    endcase
  end

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (ir[15:13]),
    .a      (a_reg),
    .b      (b_val),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= T0;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus_sel    = SEL_B;
    done       = 1'b0;
    ir_ld      = 1'b0;
    a_ld       = 1'b0;
    g_ld       = 1'b0;
    rf_we      = 1'b0;
    case (state)
      T0: begin
        if (run) begin
          ir_ld      = 1'b1;
          state_next = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            rf_we      = 1'b1;
            done       = 1'b1;
            state_next = T0;
          end
          OP_MVT: begin
            bus_sel    = SEL_MVT;
            rf_we      = 1'b1;
            done       = 1'b1;
            state_next = T0;
          end
          OP_RSV: begin
            done       = 1'b1;
            state_next = T0;
          end
          default: begin
            bus_sel    = SEL_RX;
            a_ld       = 1'b1;
            state_next = T2;
          end
        endcase
      end
      T2: begin
        g_ld       = 1'b1;
        state_next = T3;
      end
      T3: begin
        bus_sel    = SEL_G;
        rf_we      = (op != OP_CMP);
        done       = 1'b1;
        state_next = T0;
      end
      default: state_next = T0;
    endcase
  end

  // Writes to an unimplemented rX simply match no register and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir    <= '0;
      a_reg <= '0;
      g_reg <= '0;
      flags <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (ir_ld) ir <= din;
      if (a_ld)  a_reg <= bus;
      if (g_ld) begin
        g_reg <= alu_result;
        flags <= alu_flags;
      end
      for (int i = 0; i < NREG; i++) begin
        if (rf_we && rx == i[2:0]) regs[i] <= bus;
      end
    end
  end

endmodule

// File: tb/tb_proc_multicycle_gen.sv
// Bench for proc_multicycle_gen: a 16-bit/4-register core driven from a vector
// table through a scoreboard, and a 32-bit/8-register core for wide and back-to-back cases.
module tb_proc_multicycle_gen;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  reg_idx;
    logic [15:0] value;
    logic [2:0]  flags;
    int          cycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din_a = '0, din_b = '0;
  logic        run_a = 1'b0, run_b = 1'b0;
  logic [2:0]  dbg_addr_a = '0, dbg_addr_b = '0;
  logic        done_a, busy_a, done_b, busy_b;
  logic [2:0]  flags_a, flags_b;
  logic [15:0] dbg_data_a;
  logic [31:0] dbg_data_b;

  vec_t vecs[14];
  vec_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  proc_multicycle_gen #(.DATA_W(16), .NREG(4)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .run(run_a), .done(done_a), .busy(busy_a),
    .flags(flags_a), .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
  );

  proc_multicycle_gen #(.DATA_W(32), .NREG(8)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .run(run_b), .done(done_b), .busy(busy_b),
    .flags(flags_b), .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
  );

  function automatic logic [15:0] enc(input logic [2:0] op, input logic imm,
                                      input logic [2:0] rx, input logic [8:0] d);
    return {op, imm, rx, d};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts falling edges until the selected core shows done; n=0 on timeout.
  task automatic wait_done(input bit which, output int n);
    bit seen = 1'b0;
    n = 0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if ((which ? done_b : done_a) === 1'b1) begin
        seen = 1'b1;
        n = k;
      end
    end
    if (!seen) check_output("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    vec_t e;
    int   n;
    @(negedge clk);
    din_a = v.instr;
    run_a = 1'b1;
    sb_q.push_back(v);
    @(posedge clk);
    #1 run_a = 1'b0;
    wait_done(1'b0, n);
    e = sb_q.pop_front();
    check_output($sformatf("v%0d_cycles", idx), n + 1, e.cycles);
    @(posedge clk);
    #1 dbg_addr_a = e.reg_idx;
    #1;
    check_output($sformatf("v%0d_value", idx), {16'd0, dbg_data_a}, {16'd0, e.value});
    check_output($sformatf("v%0d_flags", idx), {29'd0, flags_a}, {29'd0, e.flags});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    bit  saw_done;

    //            instr                          reg   value     flags  cycles
    vecs[0]  = '{enc(3'd0, 1'b1, 3'd1, 9'h1FD), 3'd1, 16'hFFFD, 3'b000, 2};
    vecs[1]  = '{enc(3'd1, 1'b1, 3'd2, 9'h0A5), 3'd2, 16'hA500, 3'b000, 2};
    vecs[2]  = '{enc(3'd2, 1'b1, 3'd2, 9'h05A), 3'd2, 16'hA55A, 3'b010, 4};
    vecs[3]  = '{enc(3'd0, 1'b1, 3'd3, 9'h005), 3'd3, 16'h0005, 3'b010, 2};
    vecs[4]  = '{enc(3'd3, 1'b1, 3'd3, 9'h005), 3'd3, 16'h0000, 3'b101, 4};
    vecs[5]  = '{enc(3'd6, 1'b1, 3'd3, 9'h001), 3'd3, 16'h0000, 3'b010, 4};
    vecs[6]  = '{enc(3'd0, 1'b1, 3'd0, 9'h0F0), 3'd0, 16'h00F0, 3'b010, 2};
    vecs[7]  = '{enc(3'd4, 1'b0, 3'd0, 9'h002), 3'd0, 16'h0050, 3'b000, 4};
    vecs[8]  = '{enc(3'd5, 1'b0, 3'd1, 9'h000), 3'd1, 16'hFFFD, 3'b010, 4};
    vecs[9]  = '{enc(3'd2, 1'b0, 3'd1, 9'h001), 3'd1, 16'hFFFA, 3'b011, 4};
    vecs[10] = '{enc(3'd0, 1'b1, 3'd6, 9'h007), 3'd6, 16'h0000, 3'b011, 2};
    vecs[11] = '{enc(3'd7, 1'b0, 3'd0, 9'h000), 3'd0, 16'h0050, 3'b011, 2};
    vecs[12] = '{enc(3'd3, 1'b0, 3'd0, 9'h001), 3'd0, 16'h0056, 3'b000, 4};
    vecs[13] = '{enc(3'd2, 1'b0, 3'd2, 9'h006), 3'd2, 16'hA55A, 3'b010, 4};

    repeat (3) @(negedge clk);
    check_output("rst_done", {31'd0, done_a}, 32'd0);
    check_output("rst_busy", {31'd0, busy_a}, 32'd0);
    check_output("rst_flags", {29'd0, flags_a}, 32'd0);
    check_output("rst_r0", {16'd0, dbg_data_a}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) apply_stimulus(i, vecs[i]);

    // Reset while an add sits in T2: no write-back, no done, all state cleared.
    @(negedge clk);
    din_a = enc(3'd2, 1'b1, 3'd2, 9'h001);
    run_a = 1'b1;
    @(posedge clk);
    #1 run_a = 1'b0;
    @(negedge clk);
    check_output("abort_busy_t1", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 dbg_addr_a = 3'd2;
    #1;
    check_output("abort_done", {31'd0, done_a}, 32'd0);
    check_output("abort_busy", {31'd0, busy_a}, 32'd0);
    check_output("abort_flags", {29'd0, flags_a}, 32'd0);
    check_output("abort_r2", {16'd0, dbg_data_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || busy_a !== 1'b0) saw_done = 1'b1;
    end
    check_output("abort_idle_after", {31'd0, saw_done}, 32'd0);
    dbg_addr_a = 3'd1;
    #1 check_output("abort_r1", {16'd0, dbg_data_a}, 32'd0);

    // Wide core: R0 = all ones, then two add R0,#1 with run held high.
    @(negedge clk);
    din_b = enc(3'd0, 1'b1, 3'd0, 9'h1FF);
    run_b = 1'b1;
    @(posedge clk);
    #1 run_b = 1'b0;
    wait_done(1'b1, n);
    check_output("w_mv_cycles", n + 1, 2);
    @(posedge clk);
    #1 dbg_addr_b = 3'd0;
    #1 check_output("w_r0_ones", dbg_data_b, 32'hFFFF_FFFF);

    @(negedge clk);
    din_b = enc(3'd2, 1'b1, 3'd0, 9'h001);
    run_b = 1'b1;
    wait_done(1'b1, n);
    check_output("w_add1_cycles", n + 1, 4);
    check_output("w_old_value", dbg_data_b, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    #1 check_output("w_add1_r0", dbg_data_b, 32'h0);
    check_output("w_add1_flags", {29'd0, flags_b}, {29'd0, 3'b101});
    wait_done(1'b1, n);
    check_output("w_b2b_gap", n, 4);
    run_b = 1'b0;
    @(posedge clk);
    #1;
    #1 check_output("w_add2_r0", dbg_data_b, 32'h1);
    check_output("w_add2_flags", {29'd0, flags_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_output("w_idle_busy", {31'd0, busy_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
